// File: rtl/dynamixel_pkg.sv
// dynamixel_pkg: shared packet constants, scheduler state encoding and packet timing helper.
package dynamixel_pkg;
  localparam int PACKET_BYTES = 34;
  localparam int BITS_PER_BYTE = 10;

  typedef enum logic [2:0] {HOLDOFF, IDLE, SEND, TRANSMIT, GAP} sched_state_e;

  function automatic int packet_clocks(input int clocks_per_bit);
    return PACKET_BYTES * BITS_PER_BYTE * clocks_per_bit;
  endfunction
endpackage

// File: rtl/dynamixel_rr_arbiter.sv
// dynamixel_rr_arbiter: combinational round-robin pick, searching upward from ptr_i with wrap.
module dynamixel_rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0] req_valid_i,
  input  logic [2:0]   ptr_i,
  output logic [N-1:0] grant_o,
  output logic [2:0]   index_o,
  output logic         any_o
);
  int idx;

  // Scan offsets from farthest to nearest so the nearest valid index is the last one written.
  always_comb begin
    grant_o = '0;
    index_o = '0;
    idx = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % N;
      if (req_valid_i[idx]) begin
        grant_o = '0;
        grant_o[idx] = 1'b1;
        index_o = 3'(idx);
      end
    end
  end

  assign any_o = |req_valid_i;
endmodule

// File: rtl/dynamixel_write_scheduler.sv
// dynamixel_write_scheduler: round-robin sharing of one sync-write packet engine with on-air timing.
// Optional idle re-send of the last packet when DYNAMIXEL_SCHED_REFRESH_EN is defined.
module dynamixel_write_scheduler
  import dynamixel_pkg::*;
#(
  parameter int clocks_per_bit = 1,
  parameter int num_requesters = 3,
  parameter int gap_bits       = 16,
  parameter int refresh_clocks = 1000000
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [num_requesters-1:0]     req_valid,
  output logic [num_requesters-1:0]     req_ready,
  input  logic [16*num_requesters-1:0]  req_address,
  input  logic [128*num_requesters-1:0] req_value,
  output logic                          send,
  output logic [15:0]                   address,
  output logic [31:0]                   value1,
  output logic [31:0]                   value2,
  output logic [31:0]                   value3,
  output logic [31:0]                   value4,
  output logic [2:0]                    grant_id,
  output logic                          busy,
  output logic                          refreshing
);
  localparam int PKT_CLOCKS = packet_clocks(clocks_per_bit);
  localparam int GAP_CLOCKS = gap_bits * clocks_per_bit;
  localparam logic [31:0] HOLD_LAST = 32'(PKT_CLOCKS + GAP_CLOCKS - 1);
  localparam logic [31:0] PKT_LAST  = 32'(PKT_CLOCKS - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CLOCKS - 1);

  sched_state_e              state_q;
  logic [31:0]               timer_q;
  logic [2:0]                ptr_q;
  logic [2:0]                grant_q;
  logic [15:0]               addr_q;
  logic [127:0]              val_q;
  logic                      refreshing_q;
  logic [num_requesters-1:0] grant;
  logic [2:0]                gidx;
  logic                      any_valid;
  logic                      refresh_fire;

  dynamixel_rr_arbiter #(.N(num_requesters)) u_arb (
    .req_valid_i(req_valid),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .index_o    (gidx),
    .any_o      (any_valid)
  );

`ifdef DYNAMIXEL_SCHED_REFRESH_EN
  logic [31:0] idle_cnt_q;
  logic        primed_q;

  assign refresh_fire = (state_q == IDLE) && !any_valid && primed_q &&
                        (idle_cnt_q == 32'(refresh_clocks - 1));

  // Counts idle cycles only once a real packet exists to repeat.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt_q <= '0;
      primed_q <= 1'b0;
    end else if (state_q == IDLE) begin
      primed_q <= primed_q | any_valid;
      idle_cnt_q <= (any_valid || refresh_fire) ? '0 : (primed_q ? idle_cnt_q + 1'b1 : idle_cnt_q);
    end
  end
`else
  assign refresh_fire = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HOLDOFF;
      timer_q <= '0;
      ptr_q <= '0;
      grant_q <= '0;
      addr_q <= '0;
      val_q <= '0;
      refreshing_q <= 1'b0;
    end else begin
      case (state_q)
        HOLDOFF: begin
          state_q <= (timer_q == HOLD_LAST) ? IDLE : HOLDOFF;
          timer_q <= (timer_q == HOLD_LAST) ? '0 : timer_q + 1'b1;
        end
        IDLE: begin
          if (any_valid) begin
            addr_q <= req_address[16*int'(gidx) +: 16];
            val_q <= req_value[128*int'(gidx) +: 128];
            grant_q <= gidx;
            ptr_q <= (gidx == 3'(num_requesters - 1)) ? 3'd0 : gidx + 3'd1;
            refreshing_q <= 1'b0;
            state_q <= SEND;
          end else if (refresh_fire) begin
            refreshing_q <= 1'b1;
            state_q <= SEND;
          end
        end
        SEND: begin
          timer_q <= 32'd1;
          state_q <= TRANSMIT;
        end
        TRANSMIT: begin
          state_q <= (timer_q == PKT_LAST) ? GAP : TRANSMIT;
          timer_q <= (timer_q == PKT_LAST) ? '0 : timer_q + 1'b1;
        end
        GAP: begin
          if (timer_q == GAP_LAST) begin
            state_q <= IDLE;
            timer_q <= '0;
            refreshing_q <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= HOLDOFF;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE) ? grant : '0;
  assign send       = (state_q == SEND);
  assign busy       = (state_q == SEND) || (state_q == TRANSMIT) || (state_q == GAP);
  assign refreshing = refreshing_q;
  assign grant_id   = grant_q;
  assign address    = addr_q;
  assign value1     = val_q[31:0];
  assign value2     = val_q[63:32];
  assign value3     = val_q[95:64];
  assign value4     = val_q[127:96];
endmodule
